ddr_rx_deser: RTL and testbench

- DDR input receiver. Counterpart to the ODDR-driven output path: takes the two per-clock bit samples from an IDDR primitive, q0 (earlier in time) and q1 (later), and rebuilds the serial bitstream.
- Hunts for a sync word at either bit phase and locks word alignment.
- Once locked, outputs fixed-length frames of data words and supervises the sync word between frames.
- Sits directly behind the IDDR on an input pin, in the clk domain.

---
 rtl/ddr_rx_deser.sv | 155 +++++++++++++++
 tb/tb_ddr_rx_deser.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/ddr_rx_deser.sv
// DDR input deserialiser: rebuilds the serial stream from IDDR q0/q1 pairs,
// hunts for the sync word at either bit phase and emits framed data words.
module ddr_rx_deser #(
   parameter int                WORD_W    = 8,
   parameter logic [WORD_W-1:0] SYNC      = 8'hA5,
   parameter int                FRAME_LEN = 4,
   parameter int                MAX_MISS  = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              q0_i,
   input  logic              q1_i,
   input  logic              relock_i,
   output logic [WORD_W-1:0] data_o,
   output logic              data_valid_o,
   output logic              sof_o,
   output logic              locked_o,
   output logic              phase_o,
   output logic              sync_err_o
);

   localparam int HALF   = WORD_W / 2;
   localparam int CNT_W  = $clog2(HALF);
   localparam int IDX_W  = $clog2(FRAME_LEN + 2);
   localparam int MISS_W = $clog2(MAX_MISS + 1);

   localparam logic [CNT_W-1:0]  CNT_RELOAD = CNT_W'(HALF - 1);
   localparam logic [IDX_W-1:0]  LAST_DATA  = IDX_W'(FRAME_LEN);
   localparam logic [MISS_W-1:0] MISS_LAST  = MISS_W'(MAX_MISS - 1);

   typedef enum logic {
      HUNT,
      LOCKED
   } state_t;

   state_t              state_q, state_d;
   logic [WORD_W:0]     sr_q, sr_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [IDX_W-1:0]    idx_q, idx_d;
   logic [MISS_W-1:0]   miss_q, miss_d;
   logic                phase_q, phase_d;
   logic [WORD_W-1:0]   data_q, data_d;
   logic                valid_q, valid_d;
   logic                sof_q, sof_d;
   logic                err_q, err_d;
   logic                locked_q, locked_d;

   logic [WORD_W-1:0]   win0, win1, word;
   logic                hit0, hit1, boundary;

   // The later bit of each pair lands in the LSB, so win1 is one bit older.
   assign win0     = sr_q[WORD_W-1:0];
   assign win1     = sr_q[WORD_W:1];
   assign word     = phase_q ? win1 : win0;
   assign hit0     = (win0 == SYNC);
   assign hit1     = (win1 == SYNC);
   assign boundary = (cnt_q == '0);

   always_comb begin
      sr_d    = {sr_q[WORD_W-2:0], q0_i, q1_i};
      state_d = state_q;
      cnt_d   = cnt_q;
      idx_d   = idx_q;
      miss_d  = miss_q;
      phase_d = phase_q;
      data_d  = data_q;
      valid_d = 1'b0;
      sof_d   = 1'b0;
      err_d   = 1'b0;

      if (relock_i) begin
         state_d = HUNT;
         miss_d  = '0;
      end else begin
         case (state_q)
            HUNT: begin
               // Phase 0 takes priority when both windows hold the sync word.
               if (hit0 || hit1) begin
                  state_d = LOCKED;
                  phase_d = !hit0;
                  idx_d   = '0;
                  miss_d  = '0;
                  cnt_d   = CNT_RELOAD;
               end
            end
            LOCKED: begin
               if (boundary) begin
                  cnt_d = CNT_RELOAD;
                  if (idx_q != LAST_DATA) begin
                     idx_d   = idx_q + 1'b1;
                     data_d  = word;
                     valid_d = 1'b1;
                     sof_d   = (idx_q == '0);
                  end else begin
                     // idx_q == FRAME_LEN: this word is the sync between frames.
                     idx_d = '0;
                     if (word == SYNC) begin
                        miss_d = '0;
                     end else begin
                        err_d = 1'b1;
                        if (miss_q == MISS_LAST) begin
                           state_d = HUNT;
                           miss_d  = '0;
                        end else begin
                           miss_d = miss_q + 1'b1;
                        end
                     end
                  end
               end else begin
                  cnt_d = cnt_q - 1'b1;
               end
            end
            default: state_d = HUNT;
         endcase
      end

      locked_d = (state_d == LOCKED);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= HUNT;
         sr_q     <= '0;
         cnt_q    <= '0;
         idx_q    <= '0;
         miss_q   <= '0;
         phase_q  <= 1'b0;
         data_q   <= '0;
         valid_q  <= 1'b0;
         sof_q    <= 1'b0;
         err_q    <= 1'b0;
         locked_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         sr_q     <= sr_d;
         cnt_q    <= cnt_d;
         idx_q    <= idx_d;
         miss_q   <= miss_d;
         phase_q  <= phase_d;
         data_q   <= data_d;
         valid_q  <= valid_d;
         sof_q    <= sof_d;
         err_q    <= err_d;
         locked_q <= locked_d;
      end
   end

   assign data_o       = data_q;
   assign data_valid_o = valid_q;
   assign sof_o        = sof_q;
   assign locked_o     = locked_q;
   assign phase_o      = phase_q;
   assign sync_err_o   = err_q;

endmodule

// File: tb/tb_ddr_rx_deser.sv
// Directed bench for ddr_rx_deser: bit-serial stimulus with hand-placed
// expected lock, data and sync-error events keyed by cycle number.
module tb_ddr_rx_deser;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst, q0, q1, relock, q0b, q1b;
   logic [7:0] data, data2;
   logic       dataValid, sof, locked, phase, syncErr;
   logic       dataValid2, sof2, locked2, phase2, syncErr2;

   ddr_rx_deser #(.WORD_W(8), .SYNC(8'hA5), .FRAME_LEN(4), .MAX_MISS(2)) dut (
      .clk(clk), .rst(rst), .q0_i(q0), .q1_i(q1), .relock_i(relock),
      .data_o(data), .data_valid_o(dataValid), .sof_o(sof),
      .locked_o(locked), .phase_o(phase), .sync_err_o(syncErr)
   );

   // All-ones sync makes both windows match in the same cycle.
   ddr_rx_deser #(.WORD_W(8), .SYNC(8'hFF), .FRAME_LEN(4), .MAX_MISS(2)) dutFF (
      .clk(clk), .rst(rst), .q0_i(q0b), .q1_i(q1b), .relock_i(relock),
      .data_o(data2), .data_valid_o(dataValid2), .sof_o(sof2),
      .locked_o(locked2), .phase_o(phase2), .sync_err_o(syncErr2)
   );

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   int base  = 0;
   int expLock = 0;

   bit         bitQ[$];
   int         lockEv[int];
   logic [8:0] expWord[int];
   bit         errAt[int];

   task automatic checkBit(input string tag, input logic got, input logic want);
      total++;
      assert (got === want) else begin
         bad++;
         $error("[TB] FAIL %s @cyc %0d: got %b want %b", tag, cyc, got, want);
      end
   endtask

   task automatic checkByte(input string tag, input logic [7:0] got, input logic [7:0] want);
      total++;
      assert (got === want) else begin
         bad++;
         $error("[TB] FAIL %s @cyc %0d: got %h want %h", tag, cyc, got, want);
      end
   endtask

   task automatic pushWord(input logic [7:0] w);
      for (int i = 7; i >= 0; i--) bitQ.push_back(w[i]);
   endtask

   task automatic expectFrame(input int at, input logic [7:0] w0, input logic [7:0] w1,
                              input logic [7:0] w2, input logic [7:0] w3);
      expWord[at]      = {1'b1, w0};
      expWord[at + 4]  = {1'b0, w1};
      expWord[at + 8]  = {1'b0, w2};
      expWord[at + 12] = {1'b0, w3};
   endtask

   task automatic checkOutput();
      logic expValid, expSof;
      if (lockEv.exists(cyc)) begin
         expLock = lockEv[cyc];
         if (expLock != 0) checkBit("phase", phase, expLock == 2);
      end
      expValid = expWord.exists(cyc);
      expSof   = 1'b0;
      if (expValid) expSof = expWord[cyc][8];
      checkBit("locked", locked, expLock != 0);
      checkBit("valid", dataValid, expValid);
      checkBit("sof", sof, expSof);
      if (expValid) checkByte("data", data, expWord[cyc][7:0]);
      checkBit("syncErr", syncErr, errAt.exists(cyc));
   endtask

   // One clock: pop the next pair (zeros when the queue is empty), then check.
   task automatic applyStimulus();
      bit b0, b1;
      b0 = (bitQ.size() > 0) ? bitQ.pop_front() : 1'b0;
      b1 = (bitQ.size() > 0) ? bitQ.pop_front() : 1'b0;
      q0 = b0;
      q1 = b1;
      @(posedge clk);
      #1;
      cyc++;
      checkOutput();
   endtask

   task automatic runTo(input int target);
      while (cyc < target) applyStimulus();
   endtask

   task automatic checkAllZero(input string tag);
      checkByte({tag, "Data"}, data, 8'h00);
      checkBit({tag, "Valid"}, dataValid, 1'b0);
      checkBit({tag, "Sof"}, sof, 1'b0);
      checkBit({tag, "Locked"}, locked, 1'b0);
      checkBit({tag, "Phase"}, phase, 1'b0);
      checkBit({tag, "SyncErr"}, syncErr, 1'b0);
   endtask

   initial begin
      logic [7:0] streamA[43] = '{
         8'hA5, 8'h11, 8'h22, 8'h33, 8'h44, 8'hA5, 8'h55, 8'h66, 8'h77, 8'h88,
         8'hA5, 8'h99, 8'hAA, 8'hBB, 8'hCC, 8'hA4, 8'h12, 8'h34, 8'h56, 8'h78,
         8'hA5, 8'h01, 8'h02, 8'h03, 8'h04, 8'hA4, 8'h05, 8'h06, 8'h07, 8'h08,
         8'h00, 8'h00, 8'hA5, 8'h11, 8'h22, 8'h33, 8'h44, 8'hA5, 8'h55, 8'h66,
         8'hA5, 8'h77, 8'h88};
      logic [7:0] streamB[11] = '{
         8'hA5, 8'h11, 8'h22, 8'h33, 8'h44, 8'hA5, 8'h55, 8'h66, 8'h77, 8'h88, 8'hA5};

      rst = 1'b1; relock = 1'b0; q0 = 1'b0; q1 = 1'b0; q0b = 1'b0; q1b = 1'b0;
      $display("[TB] starting ddr_rx_deser directed run");

      // Reset held three cycles with random line activity, then released.
      for (int i = 0; i < 3; i++) begin
         bitQ.push_back(1'($urandom_range(1, 0)));
         bitQ.push_back(1'($urandom_range(1, 0)));
         applyStimulus();
         checkAllZero("reset");
      end
      rst = 1'b0;
      applyStimulus();
      checkAllZero("release");

      // Phase-0 stream: clean frames, bad syncs, loss of lock, relock, mid-frame reset.
      base = cyc;
      foreach (streamA[i]) pushWord(streamA[i]);
      lockEv[base + 5]   = 1;
      lockEv[base + 125] = 0;
      lockEv[base + 133] = 1;
      lockEv[base + 142] = 0;
      lockEv[base + 153] = 1;
      lockEv[base + 159] = 0;
      lockEv[base + 165] = 1;
      expectFrame(base + 9,   8'h11, 8'h22, 8'h33, 8'h44);
      expectFrame(base + 29,  8'h55, 8'h66, 8'h77, 8'h88);
      expectFrame(base + 49,  8'h99, 8'hAA, 8'hBB, 8'hCC);
      expectFrame(base + 69,  8'h12, 8'h34, 8'h56, 8'h78);
      expectFrame(base + 89,  8'h01, 8'h02, 8'h03, 8'h04);
      expectFrame(base + 109, 8'h05, 8'h06, 8'h07, 8'h08);
      expWord[base + 137] = {1'b1, 8'h11};
      expWord[base + 141] = {1'b0, 8'h22};
      expWord[base + 157] = {1'b1, 8'h55};
      expWord[base + 169] = {1'b1, 8'h77};
      expWord[base + 173] = {1'b0, 8'h88};
      errAt[base + 65]  = 1'b1;
      errAt[base + 105] = 1'b1;
      errAt[base + 125] = 1'b1;

      runTo(base + 141);
      relock = 1'b1;
      applyStimulus();
      relock = 1'b0;
      runTo(base + 158);
      rst = 1'b1;
      applyStimulus();
      checkAllZero("midReset");
      rst = 1'b0;
      runTo(base + 173);
      bitQ.delete();

      // Same frames shifted by one leading bit lock at phase 1.
      rst = 1'b1;
      lockEv[cyc + 1] = 0;
      applyStimulus();
      rst = 1'b0;
      base = cyc;
      bitQ.push_back(1'b0);
      foreach (streamB[i]) pushWord(streamB[i]);
      lockEv[base + 6] = 2;
      expectFrame(base + 10, 8'h11, 8'h22, 8'h33, 8'h44);
      expectFrame(base + 30, 8'h55, 8'h66, 8'h77, 8'h88);
      runTo(base + 46);
      bitQ.delete();

      // Ambiguous alignment on the all-ones sync instance must pick phase 0.
      rst = 1'b1;
      lockEv[cyc + 1] = 0;
      applyStimulus();
      rst = 1'b0;
      q0b = 1'b0; q1b = 1'b1;
      applyStimulus();
      q0b = 1'b1; q1b = 1'b1;
      for (int i = 0; i < 4; i++) applyStimulus();
      checkBit("ffLockEarly", locked2, 1'b0);
      applyStimulus();
      checkBit("ffLocked", locked2, 1'b1);
      checkBit("ffPhase", phase2, 1'b0);
      checkBit("ffSyncErr", syncErr2, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
